// File: rtl/axis_wrr_arbiter.sv
// axis_wrr_arbiter: merges four AXI-Stream slaves onto one master using
// packet-atomic weighted round-robin arbitration. A grant is held from the
// first beat of a packet through its tlast handshake. Each port may send up
// to cfg_weight packets per turn. A weight of 0 disables the port. No data
// is stored: the output is a combinational mux of the granted slave.
module axis_wrr_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int WEIGHT_WIDTH = 4
) (
  input  logic                      axis_aclk,
  input  logic                      axis_areset,
  input  logic [4*WEIGHT_WIDTH-1:0] cfg_weight,

  input  logic [DATA_WIDTH-1:0]     s0a_axis_tdata,
  input  logic                      s0a_axis_tvalid,
  input  logic                      s0a_axis_tlast,
  output logic                      s0a_axis_tready,

  input  logic [DATA_WIDTH-1:0]     s0b_axis_tdata,
  input  logic                      s0b_axis_tvalid,
  input  logic                      s0b_axis_tlast,
  output logic                      s0b_axis_tready,

  input  logic [DATA_WIDTH-1:0]     s0c_axis_tdata,
  input  logic                      s0c_axis_tvalid,
  input  logic                      s0c_axis_tlast,
  output logic                      s0c_axis_tready,

  input  logic [DATA_WIDTH-1:0]     s0d_axis_tdata,
  input  logic                      s0d_axis_tvalid,
  input  logic                      s0d_axis_tlast,
  output logic                      s0d_axis_tready,

  output logic [DATA_WIDTH-1:0]     m0k_axis_tdata,
  output logic                      m0k_axis_tvalid,
  output logic                      m0k_axis_tlast,
  output logic [1:0]                m0k_axis_tid,
  input  logic                      m0k_axis_tready,

  output logic                      busy
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                  state_reg;
  logic [1:0]              grant_reg;
  logic [WEIGHT_WIDTH-1:0] quota_reg;

  // Slave ports gathered into arrays so the mux and ready logic can be indexed.
  logic [DATA_WIDTH-1:0]   s_tdata [4];
  logic [3:0]              s_tvalid;
  logic [3:0]              s_tlast;
  logic [3:0]              s_tready;
  logic [WEIGHT_WIDTH-1:0] weight [4];
  logic [3:0]              eligible;

  assign s_tdata[0] = s0a_axis_tdata;
  assign s_tdata[1] = s0b_axis_tdata;
  assign s_tdata[2] = s0c_axis_tdata;
  assign s_tdata[3] = s0d_axis_tdata;

  assign s_tvalid = {s0d_axis_tvalid, s0c_axis_tvalid, s0b_axis_tvalid, s0a_axis_tvalid};
  assign s_tlast  = {s0d_axis_tlast,  s0c_axis_tlast,  s0b_axis_tlast,  s0a_axis_tlast};

  assign s0a_axis_tready = s_tready[0];
  assign s0b_axis_tready = s_tready[1];
  assign s0c_axis_tready = s_tready[2];
  assign s0d_axis_tready = s_tready[3];

  // Per-port weight slice, eligibility and ready gating.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_port
      assign weight[gi]   = cfg_weight[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      assign eligible[gi] = s_tvalid[gi] && (weight[gi] != '0);
      // Downstream ready reaches only the granted slave, and only mid-turn.
      assign s_tready[gi] = (state_reg == BUSY) && (grant_reg == 2'(gi)) && m0k_axis_tready;
    end
  endgenerate

  logic       any_eligible;
  logic       continue_ok;
  logic [1:0] adv_port;
  logic       last_hs;

  assign any_eligible = |eligible;
  // The current holder keeps the bus while it has quota left and is still requesting.
  assign continue_ok  = (quota_reg != '0) && eligible[grant_reg];

  // Rotating search starting just after the last grant; the last holder is checked last.
  always_comb begin
    logic       found;
    logic [1:0] cand;
    found    = 1'b0;
    cand     = grant_reg;
    adv_port = grant_reg;
    for (int k = 1; k <= 4; k++) begin
      cand = grant_reg + 2'(k);
      if (!found && eligible[cand]) begin
        found    = 1'b1;
        adv_port = cand;
      end
    end
  end

  // Output mux: the granted slave drives the master only while a turn is active.
  always_comb begin
    m0k_axis_tdata  = '0;
    m0k_axis_tvalid = 1'b0;
    m0k_axis_tlast  = 1'b0;
    m0k_axis_tid    = 2'd0;
    if (state_reg == BUSY) begin
      m0k_axis_tdata  = s_tdata[grant_reg];
      m0k_axis_tvalid = s_tvalid[grant_reg];
      m0k_axis_tlast  = s_tlast[grant_reg];
      m0k_axis_tid    = grant_reg;
    end
  end

  assign last_hs = (state_reg == BUSY) && m0k_axis_tvalid && m0k_axis_tready && m0k_axis_tlast;

  // Arbitration FSM: pick a port in IDLE, hold it until the end-of-packet handshake.
  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      state_reg <= IDLE;
      grant_reg <= 2'd3;
      quota_reg <= '0;
      busy      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_eligible) begin
            state_reg <= BUSY;
            busy      <= 1'b1;
            if (!continue_ok) begin
              // New turn: any leftover quota of the previous holder is dropped here.
              grant_reg <= adv_port;
              quota_reg <= weight[adv_port];
            end
          end
        end
        BUSY: begin
          if (last_hs) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
            if (quota_reg != '0) begin
              quota_reg <= quota_reg - 1'b1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_wrr_arbiter.sv
// tb_axis_wrr_arbiter: table-driven, hand-written and randomized checks of
// the four-input weighted round-robin stream arbiter.
module tb_axis_wrr_arbiter;

  localparam int DW = 32;
  localparam int WW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4*WW-1:0] cfg_weight = '0;
  logic [DW-1:0] s_data [4];
  logic [3:0]    s_valid = '0;
  logic [3:0]    s_last  = '0;
  logic [3:0]    s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic [1:0]    m_tid;
  logic          m_ready = 1'b0;
  logic          busy;

  int total = 0;
  int pass  = 0;

  always #5 clk = ~clk;

  axis_wrr_arbiter #(.DATA_WIDTH(DW), .WEIGHT_WIDTH(WW)) dut (
    .axis_aclk       (clk),
    .axis_areset     (rst),
    .cfg_weight      (cfg_weight),
    .s0a_axis_tdata  (s_data[0]),
    .s0a_axis_tvalid (s_valid[0]),
    .s0a_axis_tlast  (s_last[0]),
    .s0a_axis_tready (s_ready[0]),
    .s0b_axis_tdata  (s_data[1]),
    .s0b_axis_tvalid (s_valid[1]),
    .s0b_axis_tlast  (s_last[1]),
    .s0b_axis_tready (s_ready[1]),
    .s0c_axis_tdata  (s_data[2]),
    .s0c_axis_tvalid (s_valid[2]),
    .s0c_axis_tlast  (s_last[2]),
    .s0c_axis_tready (s_ready[2]),
    .s0d_axis_tdata  (s_data[3]),
    .s0d_axis_tvalid (s_valid[3]),
    .s0d_axis_tlast  (s_last[3]),
    .s0d_axis_tready (s_ready[3]),
    .m0k_axis_tdata  (m_data),
    .m0k_axis_tvalid (m_valid),
    .m0k_axis_tlast  (m_last),
    .m0k_axis_tid    (m_tid),
    .m0k_axis_tready (m_ready),
    .busy            (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    s_valid = '0;
    s_last  = '0;
    m_ready = 1'b0;
    for (int p = 0; p < 4; p++) s_data[p] = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Every port offers a 1-beat packet tagged 0xA + port index.
  task automatic drive1(input logic [3:0] v, input logic r);
    s_valid = v;
    s_last  = 4'hF;
    for (int p = 0; p < 4; p++) s_data[p] = 32'hA + 32'(p);
    m_ready = r;
  endtask

  function automatic int w_of(input int p);
    return int'(cfg_weight[p*WW +: WW]);
  endfunction

  typedef struct {
    logic        rst_before;
    logic [15:0] weight;
    logic [3:0]  valid;
    logic        ready;
    logic        exp_busy;
    logic [1:0]  exp_tid;
    logic [3:0]  exp_tready;
    logic [31:0] exp_data;
  } vec_t;

  function automatic vec_t mk(input logic rb, input logic [15:0] w, input logic [3:0] v,
                              input logic eb, input logic [1:0] et);
    vec_t r;
    r.rst_before = rb;
    r.weight     = w;
    r.valid      = v;
    r.ready      = 1'b1;
    r.exp_busy   = eb;
    r.exp_tid    = et;
    r.exp_tready = eb ? (4'b0001 << et) : 4'b0000;
    r.exp_data   = eb ? (32'hA + 32'(et)) : 32'h0;
    return r;
  endfunction

  // ---------------- randomized test with reference model ----------------
  int seq [4];
  int beat [4];
  int plen [4];
  bit md_busy;
  int md_turn;
  int md_left;

  task automatic rnd_test(input int cycles);
    logic [3:0] el;
    logic [3:0] exp_rdy;
    bit found;
    int g;
    do_reset();
    cfg_weight = 16'h1111;
    md_busy = 0; md_turn = 3; md_left = 0;
    for (int p = 0; p < 4; p++) begin
      seq[p] = 0; beat[p] = 0; plen[p] = $urandom_range(1, 4);
    end
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 49) == 0) begin
        for (int p = 0; p < 4; p++)
          cfg_weight[p*WW +: WW] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
      end
      for (int p = 0; p < 4; p++) begin
        s_data[p]  = {2'(p), 6'd0, 24'(seq[p])};
        s_last[p]  = (beat[p] == plen[p] - 1);
        s_valid[p] = ($urandom_range(0, 99) < 65);
      end
      m_ready = ($urandom_range(0, 99) < 75);
      #1;
      exp_rdy = (md_busy && m_ready) ? (4'b0001 << md_turn) : 4'b0000;
      chk("rnd_busy", 32'(busy), 32'(md_busy));
      chk("rnd_tready", 32'(s_ready), 32'(exp_rdy));
      chk("rnd_tvalid", 32'(m_valid), md_busy ? 32'(s_valid[md_turn]) : 32'd0);
      if (md_busy) begin
        chk("rnd_tid", 32'(m_tid), 32'(md_turn));
        chk("rnd_tdata", m_data, {2'(md_turn), 6'd0, 24'(seq[md_turn])});
        chk("rnd_tlast", 32'(m_last), 32'(beat[md_turn] == plen[md_turn] - 1));
      end else begin
        chk("rnd_idle_tdata", m_data, 32'd0);
      end
      // Reference model: a turn owner with a packet budget, decided once per packet.
      if (!md_busy) begin
        for (int p = 0; p < 4; p++) el[p] = s_valid[p] && (w_of(p) != 0);
        if (el != 4'b0000) begin
          if (!(md_left > 0 && el[md_turn])) begin
            found = 0;
            for (int k = 1; k <= 4; k++) begin
              if (!found && el[(md_turn + k) % 4]) begin
                found = 1;
                md_turn = (md_turn + k) % 4;
              end
            end
            md_left = w_of(md_turn);
          end
          md_busy = 1;
        end
      end else if (s_valid[md_turn] && m_ready) begin
        g = md_turn;
        seq[g]++;
        if (beat[g] == plen[g] - 1) begin
          beat[g] = 0;
          plen[g] = $urandom_range(1, 4);
          md_busy = 0;
          if (md_left > 0) md_left--;
        end else begin
          beat[g]++;
        end
      end
      @(posedge clk);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t vecs [22];
    int nb, stall, got_n;
    bit done, hs;
    int tids [$];
    int exp_tids [4];

    for (int p = 0; p < 4; p++) s_data[p] = '0;

    // Reset state while reset is held from time 0.
    #1;
    chk("rst_tready", 32'(s_ready), 32'd0);
    chk("rst_tvalid", 32'(m_valid), 32'd0);
    chk("rst_tid",    32'(m_tid),   32'd0);
    chk("rst_busy",   32'(busy),    32'd0);
    chk("rst_tdata",  m_data,       32'd0);
    chk("rst_tlast",  32'(m_last),  32'd0);

    // Fair rotation with equal weights, then 2:1 weighting with c/d disabled.
    vecs[0]  = mk(1, 16'h1111, 4'hF, 1, 0);
    vecs[1]  = mk(0, 16'h1111, 4'hF, 0, 0);
    vecs[2]  = mk(0, 16'h1111, 4'hF, 1, 1);
    vecs[3]  = mk(0, 16'h1111, 4'hF, 0, 0);
    vecs[4]  = mk(0, 16'h1111, 4'hF, 1, 2);
    vecs[5]  = mk(0, 16'h1111, 4'hF, 0, 0);
    vecs[6]  = mk(0, 16'h1111, 4'hF, 1, 3);
    vecs[7]  = mk(0, 16'h1111, 4'hF, 0, 0);
    vecs[8]  = mk(0, 16'h1111, 4'hF, 1, 0);
    vecs[9]  = mk(0, 16'h1111, 4'hF, 0, 0);
    vecs[10] = mk(1, 16'h0012, 4'h3, 1, 0);
    vecs[11] = mk(0, 16'h0012, 4'h3, 0, 0);
    vecs[12] = mk(0, 16'h0012, 4'h3, 1, 0);
    vecs[13] = mk(0, 16'h0012, 4'h3, 0, 0);
    vecs[14] = mk(0, 16'h0012, 4'h3, 1, 1);
    vecs[15] = mk(0, 16'h0012, 4'h3, 0, 0);
    vecs[16] = mk(0, 16'h0012, 4'h3, 1, 0);
    vecs[17] = mk(0, 16'h0012, 4'h3, 0, 0);
    vecs[18] = mk(0, 16'h0012, 4'h3, 1, 0);
    vecs[19] = mk(0, 16'h0012, 4'h3, 0, 0);
    vecs[20] = mk(0, 16'h0012, 4'h3, 1, 1);
    vecs[21] = mk(0, 16'h0012, 4'h3, 0, 0);

    for (int i = 0; i < 22; i++) begin
      if (vecs[i].rst_before) do_reset();
      @(negedge clk);
      cfg_weight = vecs[i].weight;
      drive1(vecs[i].valid, vecs[i].ready);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_tready", i), 32'(s_ready), 32'(vecs[i].exp_tready));
      chk($sformatf("vec%0d_tdata", i), m_data, vecs[i].exp_data);
      if (vecs[i].exp_busy) chk($sformatf("vec%0d_tid", i), 32'(m_tid), 32'(vecs[i].exp_tid));
    end

    // Single source: 3-beat packet on port a, one cycle arbitration latency.
    do_reset();
    cfg_weight = 16'h1111;
    @(negedge clk);
    s_valid = 4'b0001; s_data[0] = 32'd0; s_last = 4'b0000; m_ready = 1'b1;
    #1;
    chk("ss_pre_tvalid", 32'(m_valid), 32'd0);
    chk("ss_pre_busy", 32'(busy), 32'd0);
    @(posedge clk);
    nb = 0; done = 0; got_n = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      s_valid = 4'b0001; s_data[0] = 32'(nb); s_last = {3'b000, nb == 2};
      #1;
      if (c == 0) chk("ss_first_valid", 32'(m_valid), 32'd1);
      chk("ss_tid", 32'(m_tid), 32'd0);
      hs = m_valid && m_ready;
      if (hs) begin
        got_n++;
        chk("ss_tdata", m_data, 32'(nb));
        chk("ss_tlast", 32'(m_last), 32'(nb == 2));
      end
      @(posedge clk);
      if (hs) begin
        if (nb == 2) done = 1;
        nb++;
      end
    end
    chk("ss_done", 32'(done), 32'd1);
    chk("ss_beats", 32'(got_n), 32'd3);
    @(negedge clk);
    s_valid = 4'b0000;
    #1;
    chk("ss_busy_drop", 32'(busy), 32'd0);

    // Backpressure: 4-beat packet from b, ready low for 3 cycles after beat 1,
    // with a and c requesting throughout.
    do_reset();
    cfg_weight = 16'h1111;
    @(negedge clk);
    s_valid = 4'b0010; s_data[1] = 32'd100; s_last = 4'b0000; m_ready = 1'b1;
    @(posedge clk);
    nb = 0; stall = 0; got_n = 0; done = 0;
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge clk);
      drive1(4'b0111, (stall == 0));
      s_data[1] = 32'd100 + 32'(nb);
      s_last[1] = (nb == 3);
      #1;
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_tid", 32'(m_tid), 32'd1);
      chk("bp_tready", 32'(s_ready), m_ready ? 32'h2 : 32'h0);
      hs = m_valid && m_ready;
      if (hs) begin
        got_n++;
        chk("bp_tdata", m_data, 32'd100 + 32'(nb));
      end
      @(posedge clk);
      if (hs) begin
        if (nb == 3) done = 1;
        if (nb == 1) stall = 3;
        nb++;
      end else if (stall > 0) begin
        stall--;
      end
    end
    chk("bp_done", 32'(done), 32'd1);
    chk("bp_beats", 32'(got_n), 32'd4);

    // Early release and quota reload: a has weight 3.
    do_reset();
    cfg_weight = 16'h1113;
    @(negedge clk); drive1(4'b0101, 1'b1); #1;
    chk("er_idle", 32'(busy), 32'd0);
    @(posedge clk);
    @(negedge clk); drive1(4'b0101, 1'b1); #1;
    chk("er_a_tid", 32'(m_tid), 32'd0);
    chk("er_a_busy", 32'(busy), 32'd1);
    @(posedge clk);
    @(negedge clk); drive1(4'b0100, 1'b1); #1;
    chk("er_bubble", 32'(busy), 32'd0);
    @(posedge clk);
    @(negedge clk); drive1(4'b0100, 1'b1); #1;
    chk("er_c_busy", 32'(busy), 32'd1);
    chk("er_c_tid", 32'(m_tid), 32'd2);
    @(posedge clk);
    tids = {};
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); drive1(4'b0101, 1'b1); #1;
      if (busy) tids.push_back(int'(m_tid));
      @(posedge clk);
    end
    exp_tids = '{0, 0, 0, 2};
    chk("er_count", 32'(tids.size()), 32'd4);
    for (int i = 0; i < 4 && i < tids.size(); i++)
      chk($sformatf("er_seq%0d", i), 32'(tids[i]), 32'(exp_tids[i]));

    // Asynchronous reset in the middle of a packet.
    do_reset();
    cfg_weight = 16'h1111;
    @(negedge clk);
    s_valid = 4'b0001; s_data[0] = 32'h55; s_last = 4'b0000; m_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("mr_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mr_tready", 32'(s_ready), 32'd0);
    chk("mr_tvalid", 32'(m_valid), 32'd0);
    chk("mr_tid", 32'(m_tid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_tdata", m_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic against the reference model.
    rnd_test(3000);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", pass, total);
    $fatal(1, "timeout");
  end

endmodule
